// File: rtl/lcd_reader.sv
// Read-side controller for an HD44780-style LCD in 4-bit mode: status or data-RAM
// reads as two E strobes (high nibble first), with an optional busy-flag poll loop.
module lcd_reader #(
  parameter int TAS       = 2,
  parameter int TEH       = 8,
  parameter int TEL       = 16,
  parameter int MAX_POLLS = 1024,
  parameter int PW        = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_sel,
  input  logic       poll,
  input  logic [3:0] sf_d_in,
  output logic       ready,
  output logic       bus_req,
  output logic       valid,
  output logic [7:0] data_out,
  output logic       busy_flag,
  output logic [6:0] addr,
  output logic       timeout,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  localparam int CMAX0 = (TAS > TEH) ? TAS : TEH;
  localparam int CMAX  = (CMAX0 > TEL) ? CMAX0 : TEL;
  localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] TAS_L = CW'(TAS - 1);
  localparam logic [CW-1:0] TEH_L = CW'(TEH - 1);
  localparam logic [CW-1:0] TEL_L = CW'(TEL - 1);
  localparam logic [PW:0]   MAXP  = (PW+1)'(MAX_POLLS);

  typedef enum logic [2:0] {
    IDLE, SETUP, E1H, E1L, E2H, E2L, DONE
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  pcnt_q;
  logic           poll_q;
  logic           rs_q;
  logic           ready_q;
  logic           bus_req_q;
  logic           valid_q;
  logic [7:0]     data_q;
  logic           busy_q;
  logic [6:0]     addr_q;
  logic           timeout_q;
  logic           lcd_rs_q;
  logic           lcd_rw_q;
  logic           lcd_e_q;

  logic [PW:0]    pnext_d;
  logic [CW-1:0]  cnt_inc_d;

  assign pnext_d   = {1'b0, pcnt_q} + {{PW{1'b0}}, 1'b1};
  assign cnt_inc_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};

  // Each timed state is entered with cnt_q=0 and leaves on the edge where
  // cnt_q reaches its length-1, so it lasts exactly that many cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      poll_q    <= 1'b0;
      rs_q      <= 1'b0;
      ready_q   <= 1'b1;
      bus_req_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      timeout_q <= 1'b0;
      lcd_rs_q  <= 1'b0;
      lcd_rw_q  <= 1'b0;
      lcd_e_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rs_q      <= rs_sel;
            poll_q    <= poll & ~rs_sel;
            pcnt_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            bus_req_q <= 1'b1;
            lcd_rw_q  <= 1'b1;
            lcd_rs_q  <= rs_sel;
            ready_q   <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == TAS_L) begin
            cnt_q   <= '0;
            lcd_e_q <= 1'b1;
            state_q <= E1H;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        E1H: begin
          if (cnt_q == TEH_L) begin
            cnt_q       <= '0;
            data_q[7:4] <= sf_d_in;
            lcd_e_q     <= 1'b0;
            state_q     <= E1L;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        E1L: begin
          if (cnt_q == TEL_L) begin
            cnt_q   <= '0;
            lcd_e_q <= 1'b1;
            state_q <= E2H;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        E2H: begin
          if (cnt_q == TEH_L) begin
            cnt_q       <= '0;
            data_q[3:0] <= sf_d_in;
            lcd_e_q     <= 1'b0;
            state_q     <= E2L;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        E2L: begin
          if (cnt_q == TEL_L) begin
            cnt_q <= '0;
            // RS/RW never changed during the loop, so the next strobe needs no setup.
            if (poll_q && data_q[7] && (pnext_d < MAXP)) begin
              pcnt_q  <= pnext_d[PW-1:0];
              lcd_e_q <= 1'b1;
              state_q <= E1H;
            end else begin
              valid_q   <= 1'b1;
              busy_q    <= ~rs_q & data_q[7];
              addr_q    <= rs_q ? 7'd0 : data_q[6:0];
              timeout_q <= poll_q & data_q[7];
              lcd_rw_q  <= 1'b0;
              lcd_rs_q  <= 1'b0;
              state_q   <= DONE;
            end
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        DONE: begin
          bus_req_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          bus_req_q <= 1'b0;
          ready_q   <= 1'b1;
          lcd_e_q   <= 1'b0;
          lcd_rw_q  <= 1'b0;
          lcd_rs_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign bus_req   = bus_req_q;
  assign valid     = valid_q;
  assign data_out  = data_q;
  assign busy_flag = busy_q;
  assign addr      = addr_q;
  assign timeout   = timeout_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = lcd_rw_q;
  assign lcd_e     = lcd_e_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: an LCD model serves one nibble per E rise from a queue.
module tb_lcd_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       rs_sel = 1'b0;
  logic       poll = 1'b0;
  logic [3:0] sf_d_in = 4'h0;
  logic       ready, bus_req, valid, busy_flag, timeout, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] data_out;
  logic [6:0] addr;

  int total = 0;
  int bad   = 0;
  logic [3:0] nibq[$];

  lcd_reader #(.TAS(2), .TEH(8), .TEL(16), .MAX_POLLS(4), .PW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .rs_sel(rs_sel), .poll(poll),
    .sf_d_in(sf_d_in), .ready(ready), .bus_req(bus_req), .valid(valid),
    .data_out(data_out), .busy_flag(busy_flag), .addr(addr), .timeout(timeout),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
  );

  always #5 clk = ~clk;

  always @(posedge lcd_e) begin
    if (nibq.size() > 0) sf_d_in = nibq.pop_front();
    else                 sf_d_in = 4'h0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic rs, input logic pl, input int exp_n, input int exp_rises,
                         input logic [7:0] exp_d, input logic exp_bf, input logic [6:0] exp_a,
                         input logic exp_to);
    int n, rises, first_n, second_n, hi, vcnt, busc;
    logic prev_e, pin_bad;
    start = 1'b1; rs_sel = rs; poll = pl;
    @(posedge clk); #1;
    start = 1'b0; rs_sel = 1'b0; poll = 1'b0;
    chk("accept_rw", lcd_rw, 1'b1);
    chk("accept_busreq", bus_req, 1'b1);
    chk("accept_ready", ready, 1'b0);
    chk("accept_rs", lcd_rs, rs);
    chk("accept_to_clr", timeout, 1'b0);
    n = 0; rises = 0; hi = 0; prev_e = 1'b0; pin_bad = 1'b0; first_n = -1; second_n = -1;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (valid) break;
      if (lcd_e) begin
        hi++;
        if (!prev_e) begin
          if (rises == 0) first_n = n;
          else if (rises == 1) second_n = n;
          rises++;
        end
      end
      prev_e = lcd_e;
      if (lcd_rs !== rs || lcd_rw !== 1'b1 || bus_req !== 1'b1) pin_bad = 1'b1;
    end
    chk("latency", n, exp_n);
    chk("e_rises", rises, exp_rises);
    chk("e_high_cycles", hi, exp_rises * 8);
    chk("first_e_rise", first_n, 2);
    chk("second_e_rise", second_n, 26);
    chk("pins_held", pin_bad, 1'b0);
    chk("data_out", data_out, exp_d);
    chk("busy_flag", busy_flag, exp_bf);
    chk("addr", addr, exp_a);
    chk("timeout", timeout, exp_to);
    chk("done_rw", lcd_rw, 1'b0);
    chk("done_busreq", bus_req, 1'b1);
    chk("nibbles_used", nibq.size(), 0);
    // start during DONE must be dropped
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_busreq", bus_req, 1'b0);
    chk("post_ready", ready, 1'b1);
    vcnt = 0; busc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
      if (bus_req || lcd_e) busc++;
    end
    chk("single_valid", vcnt, 0);
    chk("done_start_ignored", busc, 0);
    chk("hold_data", data_out, exp_d);
    chk("hold_timeout", timeout, exp_to);
  endtask

  initial begin
    int ecnt, vcnt;
    #12;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busreq", bus_req, 1'b0);
    chk("rst_e", lcd_e, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data_out, 8'h00);
    #11 rst = 1'b1;
    @(posedge clk); #1;
    ecnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (lcd_e || bus_req || lcd_rw || !ready || valid) ecnt++;
    end
    chk("idle_quiet", ecnt, 0);

    nibq = '{4'h4, 4'hA};
    do_read(1'b0, 1'b0, 50, 2, 8'h4A, 1'b0, 7'h4A, 1'b0);
    nibq = '{4'h3, 4'h1};
    do_read(1'b1, 1'b0, 50, 2, 8'h31, 1'b0, 7'h00, 1'b0);
    nibq = '{4'h8, 4'h1};
    do_read(1'b1, 1'b1, 50, 2, 8'h81, 1'b0, 7'h00, 1'b0);
    nibq = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h5};
    do_read(1'b0, 1'b1, 194, 8, 8'h05, 1'b0, 7'h05, 1'b0);
    nibq = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0};
    do_read(1'b0, 1'b1, 194, 8, 8'h80, 1'b1, 7'h00, 1'b1);
    nibq = '{4'h2, 4'h7};
    do_read(1'b0, 1'b0, 50, 2, 8'h27, 1'b0, 7'h27, 1'b0);

    // reset in the middle of the first E-high phase
    nibq = '{4'h9, 4'h9};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !lcd_e; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_e_high", lcd_e, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_e", lcd_e, 1'b0);
    chk("arst_rw", lcd_rw, 1'b0);
    chk("arst_busreq", bus_req, 1'b0);
    chk("arst_ready", ready, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    vcnt = 0; ecnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
      if (lcd_e) ecnt++;
    end
    chk("arst_no_valid", vcnt, 0);
    chk("arst_no_e", ecnt, 0);
    chk("arst_data", data_out, 8'h00);
    nibq.delete();

    nibq = '{4'h1, 4'hC};
    do_read(1'b0, 1'b0, 50, 2, 8'h1C, 1'b0, 7'h1C, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
